// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit. It tracks destination tags from EX
// through DEPTH post-EX stages, inserts load-use bubbles and counts stall cycles.
module fwd_hazard_unit #(
    parameter int NUM_SRC  = 2,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int DEPTH    = 2,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        hold,
    input  logic                        flush_ex,
    input  logic [ADDR_W-1:0]           id_rd,
    input  logic                        id_regwrite,
    input  logic                        id_is_load,
    input  logic [NUM_SRC*ADDR_W-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [NUM_SRC*ADDR_W-1:0]   ex_src,
    output logic [NUM_SRC*SEL_W-1:0]    ex_fwd_sel,
    output logic                        stall,
    output logic [CNT_W-1:0]            stall_cnt,
    input  logic                        stat_clr
);

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              is_load;
        logic [ADDR_W-1:0] rd;
    } tag_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    tag_t             ex_q, ex_d;
    tag_t [DEPTH:1]   stg_q, stg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_s;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_s;

    function automatic logic is_writer(input tag_t t);
        return t.valid & t.regwrite & (t.rd != ADDR_W'(ZERO_REG));
    endfunction

    // Forwarding select: scan oldest to youngest so the youngest matching writer wins.
    always_comb begin
        logic [SEL_W-1:0] sel_v;
        fwd_sel_s = '0;
        sel_v     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_v = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (is_writer(stg_q[k]) && (stg_q[k].rd == ex_src[i*ADDR_W +: ADDR_W])) begin
                    sel_v = SEL_W'(k);
                end else begin
                    sel_v = sel_v;
                end
            end
            fwd_sel_s[i*SEL_W +: SEL_W] = sel_v;
        end
    end

    // Load-use detection between the load in EX and the reader in ID; a flush squashes the reader.
    always_comb begin
        logic hit_v;
        hit_v = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i] && (id_src[i*ADDR_W +: ADDR_W] == ex_q.rd)) begin
                hit_v = 1'b1;
            end else begin
                hit_v = hit_v;
            end
        end
        if (flush_ex) begin
            stall_s = 1'b0;
        end else begin
            stall_s = is_writer(ex_q) & ex_q.is_load & hit_v;
        end
    end

    // Next state: shift the tag pipe, load EX or a bubble, update the saturating counter.
    always_comb begin
        ex_d  = ex_q;
        stg_d = stg_q;
        cnt_d = cnt_q;
        if (!hold) begin
            stg_d[1] = ex_q;
            for (int k = 2; k <= DEPTH; k++) begin
                stg_d[k] = stg_q[k-1];
            end
            if (flush_ex || stall_s) begin
                ex_d = '0;
            end else begin
                ex_d.valid    = 1'b1;
                ex_d.regwrite = id_regwrite;
                ex_d.is_load  = id_is_load;
                ex_d.rd       = id_rd;
            end
            if (stat_clr) begin
                cnt_d = '0;
            end else if (stall_s && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            ex_d  = ex_q;
            stg_d = stg_q;
            cnt_d = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            stg_q <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            stg_q <= stg_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_fwd_sel = fwd_sel_s;
    assign stall      = stall_s;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed, table-driven bench for fwd_hazard_unit; a second narrow-counter
// instance shares all inputs to exercise counter saturation.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hold, flush_ex, id_regwrite, id_is_load, stat_clr;
    logic [4:0]  id_rd;
    logic [9:0]  id_src, ex_src;
    logic [1:0]  id_src_used;
    logic [3:0]  sel, sel_sat;
    logic        stall, stall_sat;
    logic [15:0] cnt;
    logic [2:0]  cnt_sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk(clk), .reset_n(reset_n), .hold(hold), .flush_ex(flush_ex),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .id_src(id_src), .id_src_used(id_src_used), .ex_src(ex_src),
        .ex_fwd_sel(sel), .stall(stall), .stall_cnt(cnt), .stat_clr(stat_clr)
    );

    fwd_hazard_unit #(.CNT_W(3)) u_sat (
        .clk(clk), .reset_n(reset_n), .hold(hold), .flush_ex(flush_ex),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .id_src(id_src), .id_src_used(id_src_used), .ex_src(ex_src),
        .ex_fwd_sel(sel_sat), .stall(stall_sat), .stall_cnt(cnt_sat), .stat_clr(stat_clr)
    );

    typedef struct {
        logic [4:0] rd;
        logic       rw, ld;
        logic [4:0] s0, s1;
        logic [1:0] used;
        logic [4:0] e0, e1;
        logic       flush, hold, clr;
        int         xs0, xs1, xst, xcnt;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(int rd, int rw, int ld, int s0, int s1, int used,
                                int e0, int e1, int flush, int hld, int clr,
                                int xs0, int xs1, int xst, int xcnt);
        vec_t v;
        v.rd = 5'(rd); v.rw = 1'(rw); v.ld = 1'(ld);
        v.s0 = 5'(s0); v.s1 = 5'(s1); v.used = 2'(used);
        v.e0 = 5'(e0); v.e1 = 5'(e1);
        v.flush = 1'(flush); v.hold = 1'(hld); v.clr = 1'(clr);
        v.xs0 = xs0; v.xs1 = xs1; v.xst = xst; v.xcnt = xcnt;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_rd       = v.rd;
        id_regwrite = v.rw;
        id_is_load  = v.ld;
        id_src      = {v.s1, v.s0};
        id_src_used = v.used;
        ex_src      = {v.e1, v.e0};
        flush_ex    = v.flush;
        hold        = v.hold;
        stat_clr    = v.clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, check after settling, then take the clock edge.
    task automatic run_row(input string tag, input vec_t v, input int chk_sel);
        drive(v);
        #1;
        if (chk_sel != 0) begin
            chk({tag, " sel0"}, int'(sel[1:0]), v.xs0);
            chk({tag, " sel1"}, int'(sel[3:2]), v.xs1);
        end
        chk({tag, " stall"}, int'(stall), v.xst);
        chk({tag, " cnt"}, int'(cnt), v.xcnt);
        step();
    endtask

    initial begin
        //          rd rw ld s0 s1 us e0 e1 fl ho cl  xs0 xs1 st cnt
        vecs[0]  = mk(31,1,0, 1, 2, 3, 0, 0, 0,0,0,  0,0,0,0);  // ADD X31
        vecs[1]  = mk(10,1,0,31,31, 3, 1, 2, 0,0,0,  0,0,0,0);  // consumer of X31
        vecs[2]  = mk( 0,0,0, 0, 0, 0,31,31, 0,0,0,  0,0,0,0);  // X31 never forwarded
        vecs[3]  = mk( 3,1,0, 1, 2, 3, 0, 0, 0,0,0,  0,0,0,0);  // ADD X3
        vecs[4]  = mk( 4,1,0, 3, 3, 3, 1, 2, 0,0,0,  0,0,0,0);  // SUB X4,X3,X3
        vecs[5]  = mk( 5,1,0, 1, 2, 3, 3, 3, 0,0,0,  1,1,0,0);  // SUB in EX: both from S1
        vecs[6]  = mk( 0,0,0, 0, 0, 0, 1, 2, 0,0,0,  0,0,0,0);  // NOP
        vecs[7]  = mk( 6,1,0, 5, 2, 3, 0, 0, 0,0,0,  0,0,0,0);  // ORR X6,X5,X2
        vecs[8]  = mk( 7,1,0, 1, 1, 3, 5, 2, 0,0,0,  2,0,0,0);  // ORR in EX: distance two
        vecs[9]  = mk( 7,1,0, 1, 1, 3, 1, 1, 0,0,0,  0,0,0,0);  // second ADD X7
        vecs[10] = mk( 8,1,0, 7, 2, 3, 1, 1, 0,0,0,  0,0,0,0);  // consumer of X7
        vecs[11] = mk( 0,0,0, 0, 0, 0, 7, 2, 0,0,0,  1,0,0,0);  // youngest writer wins
        vecs[12] = mk( 9,1,1, 1, 1, 1, 0, 0, 0,0,0,  0,0,0,0);  // LDUR X9
        vecs[13] = mk( 1,1,0, 9, 2, 3, 1, 1, 0,0,0,  0,0,1,0);  // ADD X1,X9,X2: stall
        vecs[14] = mk( 1,1,0, 9, 2, 3, 0, 0, 0,0,0,  0,0,0,1);  // bubble in EX, stall falls
        vecs[15] = mk( 0,0,0, 0, 0, 0, 9, 2, 0,0,0,  2,0,0,1);  // ADD forwards from S2
        vecs[16] = mk(11,1,1, 1, 1, 0, 0, 0, 0,0,0,  0,0,0,1);  // LDUR X11
        vecs[17] = mk(12,1,0,11,11, 3, 1, 1, 1,0,0,  2,2,0,1);  // flush beats stall
        vecs[18] = mk( 0,0,0, 0, 0, 0, 0, 0, 0,0,0,  0,0,0,1);
        vecs[19] = mk( 0,0,0, 0, 0, 0, 0, 0, 0,0,0,  0,0,0,1);
        vecs[20] = mk(13,1,1, 1, 1, 0, 0, 0, 0,0,0,  0,0,0,1);  // LDUR X13
        vecs[21] = mk(14,1,0,13, 2, 3, 1, 1, 0,1,0,  0,0,1,1);  // hold during stall
        vecs[22] = mk(14,1,0,13, 2, 3, 1, 1, 0,1,0,  0,0,1,1);
        vecs[23] = mk(14,1,0,13, 2, 3, 1, 1, 0,1,0,  0,0,1,1);
        vecs[24] = mk(14,1,0,13, 2, 3, 1, 1, 0,0,0,  0,0,1,1);  // hold released
        vecs[25] = mk(14,1,0,13, 2, 3, 0, 0, 0,0,0,  0,0,0,2);
        vecs[26] = mk( 0,0,0, 0, 0, 0,13, 2, 0,0,0,  2,0,0,2);

        // Reset: inputs that would otherwise forward or stall.
        reset_n = 1'b0;
        drive(mk(9,1,1, 9, 9, 3, 9, 9, 0,0,0, 0,0,0,0));
        step();
        step();
        chk("rst sel", int'(sel), 0);
        chk("rst stall", int'(stall), 0);
        chk("rst cnt", int'(cnt), 0);
        reset_n = 1'b1;

        for (int r = 0; r < 27; r++) begin
            run_row($sformatf("row%0d", r), vecs[r], 1);
        end

        // Saturation: seven more load-use pairs; the 3-bit counter stops at 7.
        for (int n = 1; n <= 7; n++) begin
            run_row($sformatf("satA%0d", n), mk(15,1,1, 1, 1, 0, 0, 0, 0,0,0, 0,0,0,1+n), 0);
            run_row($sformatf("satB%0d", n), mk(14,1,0,15, 2, 3, 1, 1, 0,0,0, 0,0,1,1+n), 0);
            run_row($sformatf("satC%0d", n), mk(14,1,0,15, 2, 3, 0, 0, 0,0,0, 0,0,0,2+n), 0);
            chk($sformatf("sat cnt%0d", n), int'(cnt_sat), (2 + n > 7) ? 7 : 2 + n);
        end

        // Clear during a stall cycle: that stall is not counted.
        run_row("clrA", mk(15,1,1, 1, 1, 0, 0, 0, 0,0,0, 0,0,0,9), 0);
        run_row("clrB", mk(14,1,0,15, 2, 3, 1, 1, 0,0,1, 0,0,1,9), 0);
        chk("clr sat", int'(cnt_sat), 0);
        run_row("clrC", mk(14,1,0,15, 2, 3, 0, 0, 0,0,0, 0,0,0,0), 0);
        run_row("cntA", mk(15,1,1, 1, 1, 0, 0, 0, 0,0,0, 0,0,0,0), 0);
        run_row("cntB", mk(14,1,0,15, 2, 3, 1, 1, 0,0,0, 0,0,1,0), 0);
        run_row("cntC", mk(14,1,0,15, 2, 3, 0, 0, 0,0,0, 0,0,0,1), 0);
        chk("cnt sat after clr", int'(cnt_sat), 1);

        // Asynchronous reset between edges clears live forwarding state at once.
        run_row("preA", mk( 0,0,0, 0, 0, 0,15, 2, 0,0,0, 0,0,0,1), 0);
        drive(mk(0,0,0, 0, 0, 0,14,14, 0,0,0, 0,0,0,0));
        #1;
        chk("pre-rst sel", int'(sel), 4'b0101);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async sel", int'(sel), 0);
        chk("async cnt", int'(cnt), 0);
        chk("async stall", int'(stall), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined CPU. It owns the destination-tag pipeline from EX through the last writeback-capable stage, and it selects a forwarding source for each EX-stage operand with youngest-writer priority. It also detects load-use hazards against the instruction in ID, requests a stall, and inserts the bubble itself. It counts stall cycles for performance analysis.

## Interface
- NUM_SRC, 2: number of source operands per instruction.
- ADDR_W, 5: register address width.
- ZERO_REG, 31: register index that is never written or forwarded.
- DEPTH, 2: tracked post-EX stages. Stage 1 is EX/MEM, stage DEPTH is the oldest, MEM/WB when DEPTH=2.
- CNT_W, 16: stall-counter width.
- SEL_W, derived: $clog2(DEPTH+1).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- hold  in  1  global freeze; all internal registers keep their value.
- flush_ex  in  1  the instruction entering EX this cycle is squashed, e.g. a taken branch.
- id_rd  in  ADDR_W  destination of the ID-stage instruction.
- id_regwrite  in  1  the ID-stage instruction writes id_rd.
- id_is_load  in  1  the ID-stage instruction is a load.
- id_src  in  NUM_SRC*ADDR_W  ID-stage source addresses. Slot i is bits [i*ADDR_W +: ADDR_W].
- id_src_used  in  NUM_SRC  per-slot flag: the slot is really read.
- ex_src  in  NUM_SRC*ADDR_W  EX-stage source addresses, taken from the datapath ID/EX register.
- ex_fwd_sel  out  NUM_SRC*SEL_W  per-slot forwarding select. 0 selects the register file. k (1..DEPTH) selects the result held in stage k.
- stall  out  1  freeze PC and IF/ID this cycle.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- stat_clr  in  1  synchronous clear of stall_cnt.

## Operation
- Tag entry: {valid, regwrite, is_load, rd}.
- There is one EX entry plus stage entries S[1..DEPTH].
- An entry is a writer when valid & regwrite & (rd != ZERO_REG).
- Forwarding, per slot i (combinational):
  - Find the smallest k such that S[k] is a writer and S[k].rd == ex_src[i]. Then ex_fwd_sel[i] = k.
  - If no stage matches, ex_fwd_sel[i] = 0.
  - The EX entry never forwards to itself.
- Load-use stall (combinational):
  - stall = 1 when the EX entry is a writer with is_load, and some slot i has id_src_used[i] & (id_src[i] == EX.rd).
  - stall is forced to 0 when flush_ex = 1, because the dependent instruction is being squashed.
- Register update on a clock edge, evaluated in this priority order:
  1. hold = 1: nothing changes, including stall_cnt.
  2. Otherwise, S[k] <= S[k-1] for k = 2..DEPTH, and S[1] <= EX.
  3. The EX entry then loads as follows:
     - flush_ex = 1: a bubble (valid = 0).
     - else stall = 1: a bubble.
     - else: {1, id_regwrite, id_is_load, id_rd}.
- stall_cnt update:
  - stat_clr = 1 and hold = 0: stall_cnt <= 0, and the current stall is not counted.
  - else stall = 1 and hold = 0: stall_cnt increments, saturating at 2^CNT_W-1.
- A load result therefore never reaches S[1] while a dependent instruction is in EX. The stall guarantees this, so no S[1] load-forward check exists.

## Timing
- Reset (reset_n low, asynchronous): all entries invalid and stall_cnt = 0. As a result ex_fwd_sel = 0 and stall = 0 while in reset.
- The reset release edge behaves like any other edge.
- ex_fwd_sel and stall are combinational, with zero-cycle latency from ex_src, id_src and the current tags.
- A tag written in ID at edge n is in EX for cycle n+1. It is in S[k] during cycle n+1+k.
- Load-use costs exactly one bubble:
  - stall is high for one cycle.
  - The next cycle, the load is in S[1] and the EX entry is a bubble, so stall falls.
  - The consumer reaches EX one cycle later and forwards from S[2].
- hold asserted mid-stall:
  - stall stays high.
  - Tags are frozen and stall_cnt does not increment.
- flush_ex and stall in the same cycle: flush wins. stall = 0 and the EX entry becomes a bubble.
- Source address == ZERO_REG: ex_fwd_sel is always 0 for that slot.

## Test plan
- Reset and zero register:
  - During reset -> ex_fwd_sel = 0, stall = 0, stall_cnt = 0.
  - ADD writing X31, then a consumer of X31 -> ex_fwd_sel[slot] = 0.
- Back-to-back ALU ops: ADD X3 then SUB X4,X3,X3 -> both slots of SUB in EX show ex_fwd_sel = 1.
- Distance two: ADD X5, NOP, ORR X6,X5,X2 -> slot 0 = 2, slot 1 = 0.
- Double writer: ADD X7 then ADD X7 then a consumer of X7 -> sel = 1, the youngest writer.
- Load-use: LDUR X9 then ADD X1,X9,X2:
  - stall = 1 for exactly one cycle.
  - The bubble is visible as S[1] invalid one cycle later.
  - ADD then reaches EX with sel = 2.
  - stall_cnt = 1.
- Control interactions:
  - Load-use with flush_ex = 1 -> stall = 0.
  - Load-use with hold = 1 for 3 cycles -> stall held high and stall_cnt unchanged during the hold.
  - stall_cnt preloaded to 0xFFFF with CNT_W=16 -> stays at 0xFFFF through further stalls.
  - stat_clr -> stall_cnt = 0.
